// File: rtl/interboard_pkg.sv
// rtl/interboard_pkg.sv - shared constants and helpers for the inter-board transmitter
package interboard_pkg;
    localparam int TX_COUNT_W     = 16;
    localparam int DATA_W_DEFAULT = 11;

    // Channel index width; a single channel still needs one bit.
    function automatic int ch_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction
endpackage

// File: rtl/interboard_tx_rr_arbiter.sv
// rtl/interboard_tx_rr_arbiter.sv - round-robin arbiter, priority starts after the last grant
module rr_arbiter
    import interboard_pkg::*;
#(
    parameter int NUM_CH = 2
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [NUM_CH-1:0] req,
    input  logic              advance,
    output logic [NUM_CH-1:0] grant
);
    localparam int CH_W = ch_width(NUM_CH);

    logic [CH_W-1:0] ptr;
    logic [CH_W-1:0] gidx;
    logic [CH_W-1:0] nxt;
    logic            found;

    always_comb begin
        grant = '0;
        gidx  = '0;
        found = 1'b0;
        for (int i = 0; i < NUM_CH; i++) begin
            logic [CH_W-1:0] sel;
            sel = CH_W'((int'(ptr) + i) % NUM_CH);
            if (!found && req[sel]) begin
                grant[sel] = 1'b1;
                gidx       = sel;
                found      = 1'b1;
            end
        end
        nxt = (gidx == CH_W'(NUM_CH - 1)) ? '0 : gidx + CH_W'(1);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            ptr <= '0;
        end else if (advance && found) begin
            ptr <= nxt;
        end
    end
endmodule

// File: rtl/interboard_tx.sv
// rtl/interboard_tx.sv - multi-channel FIFO-to-board transmitter with optional packet lock
module interboard_tx
    import interboard_pkg::*;
#(
    parameter int DATA_W   = DATA_W_DEFAULT,
    parameter int NUM_CH   = 2,
    parameter int PKT_MODE = 0,
    parameter int TAIL_BIT = DATA_W - 1,
    localparam int CH_W    = ch_width(NUM_CH)
) (
    input  logic                     input_clk,
    input  logic                     reset,
    input  logic [NUM_CH*DATA_W-1:0] fifo_data,
    input  logic [NUM_CH-1:0]        empty,
    output logic [NUM_CH-1:0]        rdreq,
    input  logic                     read_input,
    output logic                     valid,
    output logic [DATA_W-1:0]        send_data,
    output logic [CH_W-1:0]          send_ch,
    output logic [TX_COUNT_W-1:0]    tx_count
);
    logic              locked;
    logic [CH_W-1:0]   lock_ch;
    logic              transfer;
    logic              load_en;
    logic [NUM_CH-1:0] eligible;
    logic [NUM_CH-1:0] req;
    logic [NUM_CH-1:0] grant;
    logic [CH_W-1:0]   gidx;
    logic [DATA_W-1:0] gdata;

    assign transfer = valid & read_input;
    assign load_en  = ~valid | transfer;

    always_comb begin
        eligible = ~empty;
        if (locked) begin
            eligible = ~empty & (NUM_CH'(1) << lock_ch);
        end
        req = (load_en && !reset) ? eligible : '0;
    end

    rr_arbiter #(.NUM_CH(NUM_CH)) u_arb (
        .clk     (input_clk),
        .reset   (reset),
        .req     (req),
        .advance (|grant),
        .grant   (grant)
    );

    assign rdreq = grant;

    always_comb begin
        gidx = '0;
        for (int c = 0; c < NUM_CH; c++) begin
            if (grant[c]) gidx = CH_W'(c);
        end
    end

    assign gdata = fifo_data[gidx*DATA_W +: DATA_W];

    // A held word survives backpressure; a load with nothing granted drops valid.
    always_ff @(posedge input_clk) begin
        if (reset) begin
            valid     <= 1'b0;
            send_data <= '0;
            send_ch   <= '0;
            tx_count  <= '0;
            locked    <= 1'b0;
            lock_ch   <= '0;
        end else begin
            if (transfer) tx_count <= tx_count + TX_COUNT_W'(1);
            if (load_en) begin
                if (|grant) begin
                    valid     <= 1'b1;
                    send_data <= gdata;
                    send_ch   <= gidx;
                    locked    <= (PKT_MODE != 0) && !gdata[TAIL_BIT];
                    lock_ch   <= gidx;
                end else begin
                    valid <= 1'b0;
                end
            end
        end
    end
endmodule

// File: tb/tb_interboard_tx.sv
// tb/tb_interboard_tx.sv - randomized self-checking bench for interboard_tx (word and packet modes)
module tb_interboard_tx;
    localparam int N = 2;
    localparam int W = 11;

    logic         clk = 1'b0;
    logic         rst  [2];
    logic [N*W-1:0] fd [2];
    logic [N-1:0] emp  [2];
    logic [N-1:0] rd   [2];
    logic         rdy  [2];
    logic         vld  [2];
    logic [W-1:0] sd   [2];
    logic [0:0]   sc   [2];
    logic [15:0]  tc   [2];

    always #5 clk = ~clk;

    interboard_tx u_word (
        .input_clk(clk), .reset(rst[0]), .fifo_data(fd[0]), .empty(emp[0]), .rdreq(rd[0]),
        .read_input(rdy[0]), .valid(vld[0]), .send_data(sd[0]), .send_ch(sc[0]), .tx_count(tc[0])
    );

    interboard_tx #(.PKT_MODE(1)) u_pkt (
        .input_clk(clk), .reset(rst[1]), .fifo_data(fd[1]), .empty(emp[1]), .rdreq(rd[1]),
        .read_input(rdy[1]), .valid(vld[1]), .send_data(sd[1]), .send_ch(sc[1]), .tx_count(tc[1])
    );

    int n_checks = 0;
    int n_fail   = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // Bench-side FIFO contents and knobs.
    logic [W-1:0] q [2][N][$];
    int  rdy_pct  = 100;
    int  hide_pct = 0;
    bit  rst_req [2];

    // Reference model: output register, counter, last granted channel, locked channel (-1 = none).
    bit           m_valid [2];
    logic [W-1:0] m_data  [2];
    int           m_ch    [2];
    int           m_cnt   [2];
    int           m_last  [2];
    int           m_lock  [2];
    logic [N-1:0] last_rd [2];

    task automatic model_reset(input int d);
        m_valid[d] = 0;
        m_cnt[d]   = 0;
        m_last[d]  = N - 1;
        m_lock[d]  = -1;
    endtask

    task automatic cycle();
        for (int d = 0; d < 2; d++) begin
            rst[d] = rst_req[d];
            rdy[d] = ($urandom_range(99) < rdy_pct);
            for (int c = 0; c < N; c++) begin
                emp[d][c] = (q[d][c].size() == 0) || ($urandom_range(99) < hide_pct);
                fd[d][c*W +: W] = (q[d][c].size() != 0) ? q[d][c][0] : W'($urandom);
            end
        end
        #1;
        for (int d = 0; d < 2; d++) begin
            int pick;
            bit xfer, load;
            logic [N-1:0] exp_rd;
            pick = -1;
            xfer = m_valid[d] && rdy[d];
            load = !m_valid[d] || xfer;
            if (!rst[d] && load) begin
                for (int i = 0; i < N; i++) begin
                    int c;
                    c = (m_last[d] + 1 + i) % N;
                    if (pick < 0 && !emp[d][c] && (m_lock[d] < 0 || m_lock[d] == c)) pick = c;
                end
            end
            exp_rd = (pick >= 0) ? N'(1 << pick) : '0;
            last_rd[d] = rd[d];
            check($sformatf("rdreq%0d", d), rd[d], exp_rd);
            if (rst[d]) begin
                model_reset(d);
            end else begin
                if (xfer) m_cnt[d] = (m_cnt[d] + 1) & 16'hFFFF;
                if (load) begin
                    if (pick >= 0) begin
                        m_data[d]  = q[d][pick].pop_front();
                        m_valid[d] = 1;
                        m_ch[d]    = pick;
                        m_last[d]  = pick;
                        if (d == 1) m_lock[d] = m_data[d][W-1] ? -1 : pick;
                    end else begin
                        m_valid[d] = 0;
                    end
                end
            end
        end
        @(negedge clk);
        for (int d = 0; d < 2; d++) begin
            check($sformatf("valid%0d", d), vld[d], m_valid[d]);
            if (m_valid[d]) begin
                check($sformatf("data%0d", d), sd[d], m_data[d]);
                check($sformatf("ch%0d", d), sc[d], m_ch[d]);
            end
            check($sformatf("count%0d", d), tc[d], m_cnt[d]);
        end
    endtask

    task automatic reset_all();
        for (int d = 0; d < 2; d++) begin
            for (int c = 0; c < N; c++) q[d][c].delete();
            rst_req[d] = 1;
        end
        rdy_pct = 100; hide_pct = 0;
        cycle(); cycle();
        rst_req[0] = 0; rst_req[1] = 0;
    endtask

    initial begin
        logic [15:0] saved;
        reset_all();
        check("rst_valid", vld[0], 0);
        check("rst_data", sd[0], 0);
        check("rst_ch", sc[0], 0);
        check("rst_count", tc[1], 0);

        // Two channels, ready sink: ch0 first, then ch1.
        q[0][0].push_back(11'h155);
        q[0][1].push_back(11'h2AA);
        cycle();
        check("two_rd1", last_rd[0], 2'b01);
        check("two_data1", sd[0], 11'h155);
        cycle();
        check("two_rd2", last_rd[0], 2'b10);
        check("two_data2", sd[0], 11'h2AA);
        check("two_ch2", sc[0], 1);

        // Backpressure holds the word.
        reset_all();
        q[0][0].push_back(11'h123);
        q[0][1].push_back(11'h0F0);
        rdy_pct = 0;
        cycle();
        saved = tc[0];
        for (int i = 0; i < 5; i++) cycle();
        check("bp_data", sd[0], 11'h123);
        check("bp_rd", last_rd[0], 0);
        check("bp_count", tc[0], saved);
        rdy_pct = 100;
        cycle();
        check("bp_xfer", tc[0], saved + 16'd1);

        // Packet lock: ch1 waits through the gap in ch0's packet.
        reset_all();
        q[1][0].push_back(11'h001);
        for (int i = 0; i < 4; i++) q[1][1].push_back(11'h411 + 11'(i));
        cycle();
        check("pkt_head", last_rd[1], 2'b01);
        cycle();
        check("pkt_gap1", last_rd[1], 0);
        check("pkt_bubble", vld[1], 0);
        cycle();
        check("pkt_gap2", last_rd[1], 0);
        q[1][0].push_back(11'h402);
        cycle();
        check("pkt_tail", last_rd[1], 2'b01);
        check("pkt_tail_data", sd[1], 11'h402);
        cycle();
        check("pkt_release", last_rd[1], 2'b10);

        // Reset while locked and holding a word.
        reset_all();
        q[1][0].push_back(11'h005);
        q[1][1].push_back(11'h406);
        rdy_pct = 0;
        cycle();
        check("rl_lock", vld[1], 1);
        rst_req[1] = 1;
        cycle();
        check("rl_valid", vld[1], 0);
        rst_req[1] = 0;
        rdy_pct = 100;
        q[1][0].push_back(11'h007);
        cycle();
        check("rl_first", last_rd[1], 2'b01);

        // Random traffic with occasional resets.
        reset_all();
        rdy_pct = 70; hide_pct = 20;
        for (int t = 0; t < 3000; t++) begin
            for (int d = 0; d < 2; d++) begin
                rst_req[d] = ($urandom_range(199) == 0);
                for (int c = 0; c < N; c++)
                    if (q[d][c].size() < 8 && $urandom_range(99) < 40) q[d][c].push_back(W'($urandom));
            end
            cycle();
        end

        // Continuous supply: one transfer per cycle up to the counter wrap.
        reset_all();
        for (int t = 0; t < 65536; t++) begin
            for (int c = 0; c < N; c++)
                if (q[0][c].size() < 2) q[0][c].push_back(W'($urandom));
            cycle();
        end
        check("wrap_max", tc[0], 16'hFFFF);
        cycle();
        check("wrap_zero", tc[0], 16'h0000);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end
endmodule
